// File: rtl/pwm_pulse_multi_pkg.sv
// Shared types and defaults for the multi-channel pulse-train generator.
package pwm_pulse_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_GAP    = 2'd3
  } pwm_state_e;

  localparam int PWM_CH_NUM_DEF = 4;
  localparam int PWM_WIDTH_DEF  = 32;

endpackage

// File: rtl/pwm_pulse_ch.sv
// One pulse-train channel: enable edge detect, latched settings, down-counter timers.
//   state  | meaning
//   IDLE   | output follows live idle level, waiting for enable rise
//   DELAY  | start delay running, output at latched idle level
//   ACTIVE | pulse asserted (inverted idle level)
//   GAP    | idle gap between pulses
module pwm_pulse_ch
  import pwm_pulse_multi_pkg::*;
#(
  parameter int W = PWM_WIDTH_DEF
)(
  input  logic         io_clk,
  input  logic         io_rst,
  input  logic         i_en,
  input  logic         i_level,
  input  logic [W-1:0] i_delay,
  input  logic [W-1:0] i_width,
  input  logic [W-1:0] i_gap,
  input  logic [W-1:0] i_times,
  output logic         o_pulse,
  output logic         o_valid,
  output logic         o_busy,
  output logic [W-1:0] o_cnt
);

  pwm_state_e r_state, w_state_nxt;
  logic [W-1:0] r_tmr, r_rem, r_width, r_gap, r_cnt;
  logic [W-1:0] w_tmr_nxt, w_rem_nxt, w_width_nxt, w_gap_nxt, w_cnt_nxt;
  logic r_en_d, r_level, r_cont, r_pulse, r_valid, r_busy;
  logic w_level_nxt, w_cont_nxt, w_pulse_nxt, w_valid_nxt, w_busy_nxt;
  logic w_start, w_abort, w_more, w_launch, w_finish;

  // A zero width still produces a one-cycle pulse.
  function automatic logic [W-1:0] len_m1(input logic [W-1:0] len);
    return (len == '0) ? '0 : len - W'(1);
  endfunction

  assign w_start = i_en & ~r_en_d;
  assign w_abort = ~i_en & r_en_d;
  // r_rem counts pulses still owed after the current one.
  assign w_more  = r_cont | (r_rem != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_rem_nxt   = r_rem;
    w_width_nxt = r_width;
    w_gap_nxt   = r_gap;
    w_level_nxt = r_level;
    w_cont_nxt  = r_cont;
    w_pulse_nxt = r_pulse;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = 1'b0;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pulse_nxt = i_level;
        if (w_start) begin
          w_width_nxt = i_width;
          w_gap_nxt   = i_gap;
          w_level_nxt = i_level;
          w_cont_nxt  = (i_times == '0);
          w_rem_nxt   = len_m1(i_times);
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          if (i_delay == '0) begin
            w_state_nxt = ST_ACTIVE;
            w_tmr_nxt   = len_m1(i_width);
            w_pulse_nxt = ~i_level;
            w_cnt_nxt   = W'(1);
          end else begin
            w_state_nxt = ST_DELAY;
            w_tmr_nxt   = i_delay - W'(1);
          end
        end
      end
      ST_DELAY: begin
        if (r_tmr == '0) w_launch = 1'b1;
        else             w_tmr_nxt = r_tmr - W'(1);
      end
      ST_ACTIVE: begin
        if (r_tmr == '0) begin
          if (r_gap != '0) begin
            w_state_nxt = ST_GAP;
            w_tmr_nxt   = r_gap - W'(1);
            w_pulse_nxt = r_level;
          end else if (w_more) begin
            w_launch = 1'b1;
          end else begin
            w_finish = 1'b1;
          end
        end else begin
          w_tmr_nxt = r_tmr - W'(1);
        end
      end
      ST_GAP: begin
        if (r_tmr == '0) begin
          if (w_more) w_launch = 1'b1;
          else        w_finish = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_launch) begin
      w_state_nxt = ST_ACTIVE;
      w_tmr_nxt   = len_m1(r_width);
      w_pulse_nxt = ~r_level;
      w_cnt_nxt   = r_cnt + W'(1);
      // Leaving DELAY starts the first pulse, which was already accounted for at start.
      if (r_state != ST_DELAY && !r_cont) w_rem_nxt = r_rem - W'(1);
    end

    if (w_finish || (w_abort && r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_pulse_nxt = i_level;
      w_busy_nxt  = 1'b0;
      w_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      r_state <= ST_IDLE;
      r_en_d  <= 1'b0;
      r_tmr   <= '0;
      r_rem   <= '0;
      r_width <= '0;
      r_gap   <= '0;
      r_level <= 1'b0;
      r_cont  <= 1'b0;
      r_pulse <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_en_d  <= i_en;
      r_tmr   <= w_tmr_nxt;
      r_rem   <= w_rem_nxt;
      r_width <= w_width_nxt;
      r_gap   <= w_gap_nxt;
      r_level <= w_level_nxt;
      r_cont  <= w_cont_nxt;
      r_pulse <= w_pulse_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_pulse = r_pulse;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/pwm_pulse_multi.sv
// N-channel pulse-train generator: one independent pwm_pulse_ch per channel.
module pwm_pulse_multi
  import pwm_pulse_multi_pkg::*;
#(
  parameter int CH_NUM     = PWM_CH_NUM_DEF,
  parameter int _RAM_WIDTH = PWM_WIDTH_DEF
)(
  input  logic                         io_clk,
  input  logic                         io_rst,
  input  logic [CH_NUM-1:0]            io_en,
  input  logic [CH_NUM-1:0]            io_defaultLevel,
  input  logic [CH_NUM*_RAM_WIDTH-1:0] io_startDelay,
  input  logic [CH_NUM*_RAM_WIDTH-1:0] io_pulseWidth,
  input  logic [CH_NUM*_RAM_WIDTH-1:0] io_unaccessWidth,
  input  logic [CH_NUM*_RAM_WIDTH-1:0] io_pulse_times,
  output logic [CH_NUM-1:0]            io_pulseOut,
  output logic [CH_NUM-1:0]            pulse_valid,
  output logic [CH_NUM-1:0]            pulse_busy,
  output logic [CH_NUM*_RAM_WIDTH-1:0] pulse_cnt
);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    pwm_pulse_ch #(.W(_RAM_WIDTH)) u_ch (
      .io_clk  (io_clk),
      .io_rst  (io_rst),
      .i_en    (io_en[g]),
      .i_level (io_defaultLevel[g]),
      .i_delay (io_startDelay[g*_RAM_WIDTH +: _RAM_WIDTH]),
      .i_width (io_pulseWidth[g*_RAM_WIDTH +: _RAM_WIDTH]),
      .i_gap   (io_unaccessWidth[g*_RAM_WIDTH +: _RAM_WIDTH]),
      .i_times (io_pulse_times[g*_RAM_WIDTH +: _RAM_WIDTH]),
      .o_pulse (io_pulseOut[g]),
      .o_valid (pulse_valid[g]),
      .o_busy  (pulse_busy[g]),
      .o_cnt   (pulse_cnt[g*_RAM_WIDTH +: _RAM_WIDTH])
    );
  end

endmodule
